// File: rtl/up_axi_master.sv
// up_axi_master: turns single-pulse up_* register requests into AXI4-Lite master
// transactions. It keeps one outstanding AXI transaction and one pending slot per
// direction. When both directions are pending, the write goes first.
// Optional response timeout: define UP_AXI_MASTER_TIMEOUT_EN to build it. The
// default build waits for the slave indefinitely.
module up_axi_master #(
    parameter int AXI_ADDRESS_WIDTH = 16,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                         up_clk,
    input  logic                         up_rst,
    input  logic                         up_wreq,
    input  logic [AXI_ADDRESS_WIDTH-3:0] up_waddr,
    input  logic [31:0]                  up_wdata,
    output logic                         up_wack,
    input  logic                         up_rreq,
    input  logic [AXI_ADDRESS_WIDTH-3:0] up_raddr,
    output logic [31:0]                  up_rdata,
    output logic                         up_rack,
    output logic                         up_err,
    output logic                         m_axi_awvalid,
    output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]                   m_axi_awprot,
    input  logic                         m_axi_awready,
    output logic                         m_axi_wvalid,
    output logic [31:0]                  m_axi_wdata,
    output logic [3:0]                   m_axi_wstrb,
    input  logic                         m_axi_wready,
    input  logic                         m_axi_bvalid,
    input  logic [1:0]                   m_axi_bresp,
    output logic                         m_axi_bready,
    output logic                         m_axi_arvalid,
    output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                   m_axi_arprot,
    input  logic                         m_axi_arready,
    input  logic                         m_axi_rvalid,
    input  logic [31:0]                  m_axi_rdata,
    input  logic [1:0]                   m_axi_rresp,
    output logic                         m_axi_rready
);

    localparam int UAW = AXI_ADDRESS_WIDTH - 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA
    } state_t;

    state_t          state_q, state_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            up_wack_q, up_wack_d;
    logic            up_rack_q, up_rack_d;
    logic            up_err_q, up_err_d;
    logic [31:0]     up_rdata_q, up_rdata_d;

    // Pending slots. Each slot holds one request until its transaction completes.
    logic            wr_pend_q, wr_pend_d;
    logic [UAW-1:0]  wr_addr_q, wr_addr_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic            rd_pend_q, rd_pend_d;
    logic [UAW-1:0]  rd_addr_q, rd_addr_d;
    logic            wr_clr;
    logic            rd_clr;

`ifdef UP_AXI_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]   timer_q, timer_d;
`else
    // TIMEOUT_CYCLES shapes logic only in the timeout build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Next-state, handshake, response and pending-slot logic.
    always_comb begin
        // NOTE: every signal gets a default first, so a missed branch never infers a latch.
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        up_wack_d  = 1'b0;
        up_rack_d  = 1'b0;
        up_err_d   = 1'b0;
        up_rdata_d = up_rdata_q;
        wr_clr     = 1'b0;
        rd_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_pend_q) begin
                    state_d   = ST_WR_ADDR;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else if (rd_pend_q) begin
                    state_d   = ST_RD_ADDR;
                    arvalid_d = 1'b1;
                end
            end
            ST_WR_ADDR: begin
                // AW and W retire independently. Move on once neither is still waiting.
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (m_axi_bvalid) begin
                    state_d   = ST_IDLE;
                    bready_d  = 1'b0;
                    up_wack_d = 1'b1;
                    up_err_d  = (m_axi_bresp != 2'b00);
                    wr_clr    = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                if (m_axi_arready) begin
                    state_d   = ST_RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (m_axi_rvalid) begin
                    state_d    = ST_IDLE;
                    rready_d   = 1'b0;
                    up_rack_d  = 1'b1;
                    up_rdata_d = m_axi_rdata;
                    up_err_d   = (m_axi_rresp != 2'b00);
                    rd_clr     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef UP_AXI_MASTER_TIMEOUT_EN
        // The timer reads zero on the first cycle of a transaction and counts every busy cycle.
        timer_d = (state_q == ST_IDLE) ? '0 : timer_q + TW'(1);
        if (state_q != ST_IDLE && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = ST_IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            up_err_d  = 1'b1;
            if (state_q == ST_WR_ADDR || state_q == ST_WR_RESP) begin
                up_wack_d = 1'b1;
                up_rack_d = 1'b0;
                wr_clr    = 1'b1;
            end else begin
                up_rack_d  = 1'b1;
                up_wack_d  = 1'b0;
                up_rdata_d = 32'hDEAD_DEAD;
                rd_clr     = 1'b1;
            end
        end
`endif

        // Clear first, then set: a request in the cycle its slot frees up is kept.
        // A request into a slot that is still occupied is dropped.
        wr_pend_d = wr_pend_q & ~wr_clr;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (up_wreq && !wr_pend_d) begin
            wr_pend_d = 1'b1;
            wr_addr_d = up_waddr;
            wr_data_d = up_wdata;
        end
        rd_pend_d = rd_pend_q & ~rd_clr;
        rd_addr_d = rd_addr_q;
        if (up_rreq && !rd_pend_d) begin
            rd_pend_d = 1'b1;
            rd_addr_d = up_raddr;
        end
    end

    // State register. An asynchronous reset drops every output and discards the pending slots.
    always_ff @(posedge up_clk or posedge up_rst) begin
        if (up_rst) begin
            // NOTE: the slot address/data registers are reset too; they drive the AXI address/data outputs directly.
            state_q    <= ST_IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            up_wack_q  <= 1'b0;
            up_rack_q  <= 1'b0;
            up_err_q   <= 1'b0;
            up_rdata_q <= '0;
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_pend_q  <= 1'b0;
            rd_addr_q  <= '0;
`ifdef UP_AXI_MASTER_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the pre-edge values.
            state_q    <= state_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            up_wack_q  <= up_wack_d;
            up_rack_q  <= up_rack_d;
            up_err_q   <= up_err_d;
            up_rdata_q <= up_rdata_d;
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_pend_q  <= rd_pend_d;
            rd_addr_q  <= rd_addr_d;
`ifdef UP_AXI_MASTER_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

    // Address and data come straight from the slots. A slot cannot change while its transaction is in flight.
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = {wr_addr_q, 2'b00};
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wr_data_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = {rd_addr_q, 2'b00};
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = rready_q;
    assign up_wack       = up_wack_q;
    assign up_rack       = up_rack_q;
    assign up_err        = up_err_q;
    assign up_rdata      = up_rdata_q;

endmodule
